// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register controller: FSM encoding,
// fixed register addresses and command byte layout.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  localparam int ADDR_ID      = 0;
  localparam int ADDR_LED     = 1;
  localparam int ADDR_SCRATCH = 2;
  localparam int ADDR_STATUS  = 3;

  localparam int CMD_READ_BIT = 7;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI PHY and the register controller, plus the
// register-write monitor outputs.
interface spi_reg_ctrl_if #(parameter int AW = 3);

  logic          cs_active;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [7:0]    tx_data;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (
    output cs_active, rx_valid, rx_data,
    input  tx_data, wr_strobe, wr_addr, wr_data
  );

  modport slave (
    input  cs_active, rx_valid, rx_data,
    output tx_data, wr_strobe, wr_addr, wr_data
  );

endinterface

// File: rtl/spi_reg_file.sv
// Register array with write decode, sticky error (W1C via STATUS bit0),
// combinational read mux and registered write-strobe reporting.
module spi_reg_file
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'h5A,
  parameter int         AW       = $clog2(NUM_REGS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_err_set,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata,
  output logic          o_wr_strobe,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic          o_err,
  output logic          o_led
);

  localparam logic [AW-1:0] A_ID      = AW'(ADDR_ID);
  localparam logic [AW-1:0] A_LED     = AW'(ADDR_LED);
  localparam logic [AW-1:0] A_SCRATCH = AW'(ADDR_SCRATCH);
  localparam logic [AW-1:0] A_STATUS  = AW'(ADDR_STATUS);

  logic [7:0]    r_regs [NUM_REGS];
  logic          r_err;
  logic          r_wr_strobe;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          w_accept;

  // ID writes are silently dropped; STATUS writes are accepted but only act on err
  assign w_accept = i_we && (i_waddr != A_ID);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_err       <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
    end else begin
      if (w_accept && (i_waddr != A_STATUS)) r_regs[i_waddr] <= i_wdata;
      if (i_err_set)
        r_err <= 1'b1;
      else if (w_accept && (i_waddr == A_STATUS) && i_wdata[0])
        r_err <= 1'b0;
      r_wr_strobe <= w_accept;
      if (w_accept) begin
        r_wr_addr <= i_waddr;
        r_wr_data <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = r_regs[i_raddr];
    case (i_raddr)
      A_ID:               o_rdata = ID_VALUE;
      A_STATUS:           o_rdata = {6'b0, r_regs[A_LED][0], r_err};
      A_LED, A_SCRATCH:   o_rdata = r_regs[i_raddr];
      default:            o_rdata = r_regs[i_raddr];
    endcase
  end

  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_err       = r_err;
  assign o_led       = r_regs[A_LED][0];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: command byte then data bytes with address
// auto-increment; drives the next MISO byte and the register file.
//
//  state    | meaning
//  ST_IDLE  | no transaction open, tx byte held at 0x00
//  ST_CMD   | CS open, waiting for the command byte
//  ST_WRITE | each received byte written to reg[addr], addr++
//  ST_READ  | each received byte advances addr and reloads tx with reg[addr+1]
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] ID_VALUE = 8'h5A
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  spi_reg_ctrl_if.slave   io_bus,
  output logic            o_err,
  output logic            o_led
);

  localparam int AW = $clog2(NUM_REGS);

  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic          r_oor;
  logic [7:0]    r_tx;

  logic          w_cmd_oor;
  logic          w_we;
  logic          w_err_set;
  logic [AW-1:0] w_raddr;
  logic [7:0]    w_rdata;

  // out-of-range start address poisons the whole transaction
  assign w_cmd_oor = {1'b0, io_bus.rx_data[6:0]} >= 8'(NUM_REGS);
  assign w_err_set = io_bus.rx_valid && (r_state == ST_CMD) && w_cmd_oor;
  assign w_we      = io_bus.rx_valid && (r_state == ST_WRITE) && !r_oor;
  assign w_raddr   = (r_state == ST_CMD) ? io_bus.rx_data[AW-1:0] : r_addr + AW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (io_bus.cs_active) w_next = ST_CMD;
      ST_CMD:  if (io_bus.rx_valid)
                 w_next = io_bus.rx_data[CMD_READ_BIT] ? ST_READ : ST_WRITE;
      default: ;
    endcase
    if (!io_bus.cs_active) w_next = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_oor  <= 1'b0;
      r_tx   <= 8'h00;
    end else begin
      if (io_bus.rx_valid) begin
        case (r_state)
          ST_CMD: begin
            r_addr <= io_bus.rx_data[AW-1:0];
            r_oor  <= w_cmd_oor;
            r_tx   <= (io_bus.rx_data[CMD_READ_BIT] && !w_cmd_oor) ? w_rdata : 8'h00;
          end
          ST_WRITE: begin
            r_addr <= r_addr + AW'(1);
            r_tx   <= 8'h00;
          end
          ST_READ: begin
            r_addr <= r_addr + AW'(1);
            r_tx   <= r_oor ? 8'h00 : w_rdata;
          end
          default: ;
        endcase
      end
      // a byte arriving as CS drops is processed above, then the frame closes
      if (!io_bus.cs_active) begin
        r_addr <= '0;
        r_oor  <= 1'b0;
        if (!io_bus.rx_valid) r_tx <= 8'h00;
      end
    end
  end

  spi_reg_file #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .AW       (AW)
  ) u_reg_file (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_we        (w_we),
    .i_waddr     (r_addr),
    .i_wdata     (io_bus.rx_data),
    .i_err_set   (w_err_set),
    .i_raddr     (w_raddr),
    .o_rdata     (w_rdata),
    .o_wr_strobe (io_bus.wr_strobe),
    .o_wr_addr   (io_bus.wr_addr),
    .o_wr_data   (io_bus.wr_data),
    .o_err       (o_err),
    .o_led       (o_led)
  );

  assign io_bus.tx_data = r_tx;

endmodule
